accumulator_bank: RTL and testbench



---
 rtl/accumulator_bank.sv | 183 ++++++++++++++++++
 tb/tb_accumulator_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_bank.sv
// accumulator_bank: one crossbar-side buffer bank. Accumulates routed partial
// products with signed saturation, then drains and clears every entry on request.
module accumulator_bank #(
    parameter int unsigned TILE_SIZE   = 256,
    parameter int unsigned ENTRY_COUNT = 256,
    parameter int unsigned DATA_WIDTH  = 8,
    localparam int unsigned CW = $clog2(TILE_SIZE),
    localparam int unsigned EW = $clog2(ENTRY_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            bitwidth,
    input  logic [CW-1:0]         write_row,
    input  logic [CW-1:0]         write_column,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    output logic                  bank_stall,
    input  logic                  drain_start,
    output logic                  drain_valid,
    input  logic                  drain_ready,
    output logic [EW-1:0]         drain_index,
    output logic [DATA_WIDTH-1:0] drain_data,
    output logic                  drain_done
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam logic [EW-1:0] LAST_IDX = EW'(ENTRY_COUNT - 1);
    localparam logic [DW-1:0] SAT_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [DW-1:0] mem_q [ENTRY_COUNT];

    logic          s1_valid_q, s1_valid_d;
    logic [EW-1:0] s1_idx_q,   s1_idx_d;
    logic [DW-1:0] s1_data_q,  s1_data_d;

    logic          stall_q,  stall_d;
    logic          dvalid_q, dvalid_d;
    logic [EW-1:0] didx_q,   didx_d;
    logic [DW-1:0] ddata_q,  ddata_d;
    logic          done_q,   done_d;

    logic          accept_c;
    logic          drain_fire_c;
    logic [DW:0]   sum_c;
    logic [DW-1:0] acc_c;
    logic          unused_col_c;

    // Column coordinate only selected the bank upstream.
    assign unused_col_c = ^write_column;

    assign accept_c = write_enable && !stall_q;

    // S1 capture: entry index follows the current mode, not a latched one.
    always_comb begin
        s1_valid_d = accept_c;
        s1_idx_d   = s1_idx_q;
        s1_data_d  = s1_data_q;
        if (accept_c) begin
            s1_idx_d  = EW'(write_row >> bitwidth);
            s1_data_d = write_data;
        end
    end

    // S2 add: storage already holds the previous write, so back-to-back hits chain.
    always_comb begin
        sum_c = {mem_q[s1_idx_q][DW-1], mem_q[s1_idx_q]} + {s1_data_q[DW-1], s1_data_q};
        acc_c = sum_c[DW-1:0];
        if (sum_c[DW] != sum_c[DW-1]) begin
            acc_c = sum_c[DW] ? SAT_MIN : SAT_MAX;
        end
    end

    // Next-state and registered-output logic for the accumulate/flush/drain sequence.
    always_comb begin
        state_d      = state_q;
        stall_d      = stall_q;
        dvalid_d     = dvalid_q;
        didx_d       = didx_q;
        ddata_d      = ddata_q;
        done_d       = 1'b0;
        drain_fire_c = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                stall_d = 1'b0;
                if (drain_start) begin
                    state_d = ST_FLUSH;
                    stall_d = 1'b1;
                end
            end

            ST_FLUSH: begin
                stall_d = 1'b1;
                if (!s1_valid_q) begin
                    state_d  = ST_DRAIN;
                    dvalid_d = 1'b1;
                    didx_d   = '0;
                    ddata_d  = mem_q[0];
                end
            end

            ST_DRAIN: begin
                stall_d = 1'b1;
                if (dvalid_q && drain_ready) begin
                    drain_fire_c = 1'b1;
                    if (didx_q == LAST_IDX) begin
                        state_d  = ST_ACCUM;
                        stall_d  = 1'b0;
                        dvalid_d = 1'b0;
                        didx_d   = '0;
                        ddata_d  = '0;
                        done_d   = 1'b1;
                    end else begin
                        didx_d  = didx_q + EW'(1);
                        ddata_d = mem_q[didx_q + EW'(1)];
                    end
                end
            end

            default: begin
                state_d  = ST_ACCUM;
                stall_d  = 1'b0;
                dvalid_d = 1'b0;
                didx_d   = '0;
                ddata_d  = '0;
            end
        endcase
    end

    // Control and pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ACCUM;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_data_q  <= '0;
            stall_q    <= 1'b0;
            dvalid_q   <= 1'b0;
            didx_q     <= '0;
            ddata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
            s1_data_q  <= s1_data_d;
            stall_q    <= stall_d;
            dvalid_q   <= dvalid_d;
            didx_q     <= didx_d;
            ddata_q    <= ddata_d;
            done_q     <= done_d;
        end
    end

    // Entry storage: S2 writeback and drain clear never coincide (pipeline empty in DRAIN).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRY_COUNT; i++) begin
                mem_q[i] <= '0;
            end
        end else if (s1_valid_q) begin
            mem_q[s1_idx_q] <= acc_c;
        end else if (drain_fire_c) begin
            mem_q[didx_q] <= '0;
        end
    end

    assign bank_stall  = stall_q;
    assign drain_valid = dvalid_q;
    assign drain_index = didx_q;
    assign drain_data  = ddata_q;
    assign drain_done  = done_q;

endmodule

// File: tb/tb_accumulator_bank.sv
// Scoreboard bench for accumulator_bank: directed writes, hand-computed drain images.
module tb_accumulator_bank;

    localparam int unsigned NE = 256;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] bitwidth;
    logic [7:0] write_row;
    logic [7:0] write_column;
    logic [7:0] write_data;
    logic       write_enable;
    logic       bank_stall;
    logic       drain_start;
    logic       drain_valid;
    logic       drain_ready;
    logic [7:0] drain_index;
    logic [7:0] drain_data;
    logic       drain_done;

    accumulator_bank dut (
        .clk          (clk),
        .reset        (reset),
        .bitwidth     (bitwidth),
        .write_row    (write_row),
        .write_column (write_column),
        .write_data   (write_data),
        .write_enable (write_enable),
        .bank_stall   (bank_stall),
        .drain_start  (drain_start),
        .drain_valid  (drain_valid),
        .drain_ready  (drain_ready),
        .drain_index  (drain_index),
        .drain_data   (drain_data),
        .drain_done   (drain_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_q [$];
    logic [7:0]  exp_mem [NE];
    logic        done_seen = 1'b0;
    int          beats_seen = 0;

    logic        pending_done = 1'b0;
    logic        hold_v = 1'b0;
    logic [7:0]  hold_idx, hold_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the expected beat on every accepted handshake.
    always @(negedge clk) begin
        if (reset) begin
            pending_done = 1'b0;
            hold_v       = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 32'(drain_valid), 32'd1);
                check("hold_index", 32'(drain_index), 32'(hold_idx));
                check("hold_data",  32'(drain_data),  32'(hold_data));
            end
            hold_v = 1'b0;
            if (pending_done || drain_done) begin
                check("done_pulse", 32'(drain_done), 32'(pending_done));
                check("done_valid_low", 32'(drain_valid), 32'd0);
                check("done_stall_low", 32'(bank_stall), 32'd0);
                if (drain_done) done_seen = 1'b1;
                pending_done = 1'b0;
            end
            if (drain_valid) begin
                if (drain_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_beat: got index %0d, expected none", drain_index);
                    end else begin
                        logic [15:0] e;
                        e = exp_q.pop_front();
                        check("drain_index", 32'(drain_index), 32'(e[15:8]));
                        check("drain_data",  32'(drain_data),  32'(e[7:0]));
                        beats_seen++;
                        if (e[15:8] == 8'(NE - 1)) pending_done = 1'b1;
                    end
                end else begin
                    hold_v    = 1'b1;
                    hold_idx  = drain_index;
                    hold_data = drain_data;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int row, input logic [7:0] data, input logic [1:0] bw);
        write_enable = 1'b1;
        write_row    = 8'(row);
        write_column = 8'(row + 3);
        write_data   = data;
        bitwidth     = bw;
        tick();
        write_enable = 1'b0;
    endtask

    // Queue the hand-computed image; the drain clears storage, so the image resets too.
    task automatic push_expect();
        for (int i = 0; i < int'(NE); i++) begin
            exp_q.push_back({8'(i), exp_mem[i]});
            exp_mem[i] = 8'd0;
        end
        done_seen = 1'b0;
    endtask

    task automatic start_drain();
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        check("stall_after_start", 32'(bank_stall), 32'd1);
    endtask

    task automatic wait_drain(input int pat, input bit hold_wr);
        int cyc;
        cyc = 0;
        while (!done_seen && cyc < 3000) begin
            drain_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            tick();
            cyc++;
        end
        if (hold_wr) write_enable = 1'b0;
        drain_ready = 1'b1;
        check("drain_completed", 32'(done_seen), 32'd1);
        check("beats_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic full_drain(input int pat);
        push_expect();
        start_drain();
        wait_drain(pat, 1'b0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cyc;
        reset = 1'b1; bitwidth = 2'd0; write_row = '0; write_column = '0;
        write_data = '0; write_enable = 1'b0; drain_start = 1'b0; drain_ready = 1'b1;
        for (int i = 0; i < int'(NE); i++) exp_mem[i] = 8'd0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_stall",  32'(bank_stall),  32'd0);
        check("rst_valid",  32'(drain_valid), 32'd0);
        check("rst_index",  32'(drain_index), 32'd0);
        check("rst_data",   32'(drain_data),  32'd0);
        check("rst_done",   32'(drain_done),  32'd0);

        // Empty bank drains as zeros.
        full_drain(0);

        // bitwidth=2: rows 8 and 9 both land in entry 2.
        wr(8, 8'd5, 2'd2);
        wr(9, 8'd7, 2'd2);
        exp_mem[2] = 8'd12;
        full_drain(0);

        // Positive and negative saturation.
        for (int i = 0; i < 10; i++) wr(0, 8'd20, 2'd2);
        for (int i = 0; i < 4; i++) wr(4, 8'h9C, 2'd2);
        exp_mem[0] = 8'h7F;
        exp_mem[1] = 8'h80;
        full_drain(0);

        // Back-to-back same-entry writes; last one shares its cycle with drain_start.
        for (int i = 0; i < 15; i++) wr(0, 8'd1, 2'd0);
        exp_mem[0] = 8'd16;
        push_expect();
        write_enable = 1'b1; write_row = 8'd0; write_data = 8'd1; bitwidth = 2'd0;
        drain_start = 1'b1;
        tick();
        write_enable = 1'b0; drain_start = 1'b0;
        check("stall_after_start_fwd", 32'(bank_stall), 32'd1);
        wait_drain(0, 1'b0);
        tick();

        // Back-pressure, then confirm the entry was cleared.
        wr(3, 8'd9, 2'd0);
        exp_mem[3] = 8'd9;
        full_drain(1);
        full_drain(0);

        // Write held during drain is ignored until the stall drops.
        push_expect();
        start_drain();
        write_enable = 1'b1; write_row = 8'd5; write_data = 8'd33; bitwidth = 2'd0;
        wait_drain(0, 1'b1);
        tick();
        exp_mem[5] = 8'd33;
        full_drain(0);

        // Reset at drain beat 100 discards storage, including undrained entry 200.
        wr(200, 8'd50, 2'd0);
        exp_mem[200] = 8'd50;
        push_expect();
        start_drain();
        base = beats_seen;
        cyc = 0;
        drain_ready = 1'b1;
        while (beats_seen < base + 100 && cyc < 1000) begin
            tick();
            cyc++;
        end
        check("beat100_reached", 32'(beats_seen - base), 32'd100);
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        check("midrst_valid", 32'(drain_valid), 32'd0);
        check("midrst_stall", 32'(bank_stall),  32'd0);
        check("midrst_index", 32'(drain_index), 32'd0);
        check("midrst_done",  32'(drain_done),  32'd0);
        for (int i = 0; i < int'(NE); i++) exp_mem[i] = 8'd0;
        tick();
        full_drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
